// File: rtl/regfile_mp_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb_if
//
// Bundles the decode-stage register-file bus of regfile_mp_sb: the read ports,
// the write-back ports, the scoreboard allocate port and the scoreboard view.
//
// Signals (packed, port p / w occupies slice [p*W +: W]):
//   rd_addr    NRP*AW    read addresses             (decode -> regfile)
//   rd_data    NRP*XLEN  read data                  (regfile -> decode)
//   rd_busy    NRP       register on port p busy    (regfile -> decode)
//   wr_en      NWP       per-port write enable      (write-back -> regfile)
//   wr_addr    NWP*AW    write addresses            (write-back -> regfile)
//   wr_data    NWP*XLEN  write data                 (write-back -> regfile)
//   alloc_en   1         destination allocate       (issue -> regfile)
//   alloc_addr AW        register being allocated   (issue -> regfile)
//   busy_vec   NREGS     full scoreboard state      (regfile -> decode)
//
// Modports:
//   master  the pipeline side that drives addresses, write-backs and allocates
//   slave   the register file itself
// -----------------------------------------------------------------------------
interface regfile_mp_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    parameter int NWP   = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic [NWP-1:0]      wr_en;
    logic [NWP*AW-1:0]   wr_addr;
    logic [NWP*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        output alloc_en,
        output alloc_addr,
        input  rd_data,
        input  rd_busy,
        input  busy_vec
    );

    modport slave (
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  alloc_en,
        input  alloc_addr,
        output rd_data,
        output rd_busy,
        output busy_vec
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
//
// Decode-stage register file with NRP asynchronous read ports, NWP synchronous
// write ports and a per-register busy-bit scoreboard for RAW hazard detection.
//
// Features:
//   - optional hardwired zero register (ZERO_REG): reads 0, drops writes and
//     allocates, never busy
//   - optional write-to-read bypass (BYPASS): a same-cycle write is forwarded
//     to matching read ports and also hides the busy bit it is retiring
//   - several ports writing one register in one cycle: highest port index wins
//   - synchronous reset clears every register and busy bit and overrides any
//     write or allocate presented in the same cycle
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high
//   bus    regfile_mp_sb_if.slave (read, write-back, allocate, scoreboard)
// -----------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRP      = 2,
    parameter int NWP      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    localparam bit HAS_ZERO   = (ZERO_REG != 0);
    localparam bit HAS_BYPASS = (BYPASS != 0);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;

    // -------------------------------------------------------------------------
    // Unpack the flat port vectors
    // -------------------------------------------------------------------------
    logic [AW-1:0]   wr_a [NWP];
    logic [XLEN-1:0] wr_d [NWP];
    logic [NWP-1:0]  wr_ok;   // write enable with zero-register writes removed
    logic [AW-1:0]   rd_a [NRP];

    // NOTE: every signal written in a combinational block is given a value on
    // every path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        for (int w = 0; w < NWP; w++) begin
            wr_a[w]  = bus.wr_addr[w*AW +: AW];
            wr_d[w]  = bus.wr_data[w*XLEN +: XLEN];
            wr_ok[w] = bus.wr_en[w] && !(HAS_ZERO && (wr_a[w] == '0));
        end
        for (int p = 0; p < NRP; p++) begin
            rd_a[p] = bus.rd_addr[p*AW +: AW];
        end
    end

    // -------------------------------------------------------------------------
    // Per-register write resolution
    //
    // wr_hit[r] : some port writes r this cycle (also the scoreboard clear)
    // wr_val[r] : data of the winning port; ports are scanned in ascending
    //             order so a later (higher-index) port overrides an earlier one
    // -------------------------------------------------------------------------
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int w = 0; w < NWP; w++) begin
                if (wr_ok[w] && (wr_a[w] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_d[w];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state
    //
    // A register is set by an allocate and cleared by a write-back. When both
    // land together the new producer wins, so set simply dominates clear.
    // -------------------------------------------------------------------------
    logic [NREGS-1:0] alloc_set;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        alloc_set = '0;
        if (bus.alloc_en && !(HAS_ZERO && (bus.alloc_addr == '0))) begin
            alloc_set[bus.alloc_addr] = 1'b1;
        end
        busy_nxt = alloc_set | (busy_q & ~wr_hit);
    end

    // -------------------------------------------------------------------------
    // Sequential state: register array and busy bits
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the array is reset on purpose: all registers reading 0 after reset
    // is architectural here, so this storage is flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            busy_q <= busy_nxt;
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    //
    // Priority: zero register, then bypass of the winning same-cycle write,
    // then the stored value. With bypass enabled the same-cycle write also
    // resolves the hazard, so its busy bit is hidden from the reader.
    // -------------------------------------------------------------------------
    logic [NRP*XLEN-1:0] rd_data_o;
    logic [NRP-1:0]      rd_busy_o;

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NRP; p++) begin
            if (HAS_ZERO && (rd_a[p] == '0)) begin
                rd_data_o[p*XLEN +: XLEN] = '0;
            end else if (HAS_BYPASS && wr_hit[rd_a[p]]) begin
                rd_data_o[p*XLEN +: XLEN] = wr_val[rd_a[p]];
            end else begin
                rd_data_o[p*XLEN +: XLEN] = regs[rd_a[p]];
            end
            rd_busy_o[p] = busy_q[rd_a[p]] && !(HAS_BYPASS && wr_hit[rd_a[p]]);
        end
    end

    assign bus.rd_data  = rd_data_o;
    assign bus.rd_busy  = rd_busy_o;
    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
//
// Four register-file configurations share one stimulus stream. A behavioural
// model (plain arrays, highest-port-wins lookup) predicts every output; one
// negedge process compares all outputs of all instances each cycle. Directed
// sequences with literal expectations pin the model, followed by a long
// randomised run with occasional resets.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

    // Configurations: XLEN, NREGS, NRP, NWP, BYPASS, ZERO_REG
    localparam int X0 = 32, R0 = 32, P0 = 2, W0 = 2, B0 = 1, Z0 = 1;
    localparam int X1 = 32, R1 = 32, P1 = 2, W1 = 2, B1 = 0, Z1 = 0;
    localparam int X2 = 8,  R2 = 4,  P2 = 3, W2 = 3, B2 = 1, Z2 = 0;
    localparam int X3 = 16, R3 = 2,  P3 = 1, W3 = 1, B3 = 0, Z3 = 1;
    localparam int A0 = $clog2(R0), A1 = $clog2(R1), A2 = $clog2(R2), A3 = $clog2(R3);

    localparam int NCFG = 4;
    localparam int MAXP = 3;
    localparam int MAXW = 3;
    localparam int C_X [NCFG] = '{X0, X1, X2, X3};
    localparam int C_R [NCFG] = '{R0, R1, R2, R3};
    localparam int C_P [NCFG] = '{P0, P1, P2, P3};
    localparam int C_W [NCFG] = '{W0, W1, W2, W3};
    localparam int C_B [NCFG] = '{B0, B1, B2, B3};
    localparam int C_Z [NCFG] = '{Z0, Z1, Z2, Z3};

    localparam int N_RANDOM = 10000;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_sb_if #(.XLEN(X0), .NREGS(R0), .NRP(P0), .NWP(W0)) bus0 ();
    regfile_mp_sb_if #(.XLEN(X1), .NREGS(R1), .NRP(P1), .NWP(W1)) bus1 ();
    regfile_mp_sb_if #(.XLEN(X2), .NREGS(R2), .NRP(P2), .NWP(W2)) bus2 ();
    regfile_mp_sb_if #(.XLEN(X3), .NREGS(R3), .NRP(P3), .NWP(W3)) bus3 ();

    regfile_mp_sb #(.XLEN(X0), .NREGS(R0), .NRP(P0), .NWP(W0), .BYPASS(B0), .ZERO_REG(Z0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    regfile_mp_sb #(.XLEN(X1), .NREGS(R1), .NRP(P1), .NWP(W1), .BYPASS(B1), .ZERO_REG(Z1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    regfile_mp_sb #(.XLEN(X2), .NREGS(R2), .NRP(P2), .NWP(W2), .BYPASS(B2), .ZERO_REG(Z2))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));
    regfile_mp_sb #(.XLEN(X3), .NREGS(R3), .NRP(P3), .NWP(W3), .BYPASS(B3), .ZERO_REG(Z3))
        dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // -------------------------------------------------------------------------
    // Shared generic stimulus (widest shapes; each instance takes its slice)
    // -------------------------------------------------------------------------
    logic        s_rst;
    logic [4:0]  s_ra [MAXP];
    logic        s_we [MAXW];
    logic [4:0]  s_wa [MAXW];
    logic [31:0] s_wd [MAXW];
    logic        s_ae;
    logic [4:0]  s_aa;

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [31:0] m_regs [NCFG][32];
    logic [31:0] m_busy [NCFG];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(string kind, int c, int p, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL cfg%0d %s[%0d]: got %h, expected %h", c, kind, p, got, exp);
    endtask

    function automatic logic [31:0] dmask(int c);
        if (C_X[c] >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << C_X[c]) - 32'd1;
    endfunction

    function automatic int reg_of(int c, logic [4:0] a);
        return int'(a) % C_R[c];
    endfunction

    // Port that lands its data in register r this cycle, or -1.
    function automatic int writer(int c, int r);
        if (C_Z[c] != 0 && r == 0) return -1;
        for (int w = C_W[c] - 1; w >= 0; w--) begin
            if (s_we[w] && reg_of(c, s_wa[w]) == r) return w;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_rd(int c, int p);
        int r;
        int w;
        r = reg_of(c, s_ra[p]);
        w = writer(c, r);
        if (C_Z[c] != 0 && r == 0) return 32'h0;
        if (C_B[c] != 0 && w >= 0) return s_wd[w] & dmask(c);
        return m_regs[c][r];
    endfunction

    function automatic logic exp_rb(int c, int p);
        int r;
        r = reg_of(c, s_ra[p]);
        return m_busy[c][r] && !(C_B[c] != 0 && writer(c, r) >= 0);
    endfunction

    task automatic model_edge();
        for (int c = 0; c < NCFG; c++) begin
            if (s_rst) begin
                m_busy[c] = 32'h0;
                for (int r = 0; r < 32; r++) m_regs[c][r] = 32'h0;
            end else begin
                for (int r = 0; r < C_R[c]; r++) begin
                    int  w;
                    bit  set;
                    w   = writer(c, r);
                    set = s_ae && reg_of(c, s_aa) == r && !(C_Z[c] != 0 && r == 0);
                    if (w >= 0) m_regs[c][r] = s_wd[w] & dmask(c);
                    if (set)         m_busy[c][r] = 1'b1;
                    else if (w >= 0) m_busy[c][r] = 1'b0;
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Drive all instances from the generic stimulus
    // -------------------------------------------------------------------------
    task automatic pack_inputs();
        reset = s_rst;
        for (int p = 0; p < P0; p++) bus0.rd_addr[p*A0 +: A0] = s_ra[p][A0-1:0];
        for (int w = 0; w < W0; w++) begin
            bus0.wr_en[w]             = s_we[w];
            bus0.wr_addr[w*A0 +: A0]  = s_wa[w][A0-1:0];
            bus0.wr_data[w*X0 +: X0]  = s_wd[w][X0-1:0];
        end
        bus0.alloc_en   = s_ae;
        bus0.alloc_addr = s_aa[A0-1:0];

        for (int p = 0; p < P1; p++) bus1.rd_addr[p*A1 +: A1] = s_ra[p][A1-1:0];
        for (int w = 0; w < W1; w++) begin
            bus1.wr_en[w]             = s_we[w];
            bus1.wr_addr[w*A1 +: A1]  = s_wa[w][A1-1:0];
            bus1.wr_data[w*X1 +: X1]  = s_wd[w][X1-1:0];
        end
        bus1.alloc_en   = s_ae;
        bus1.alloc_addr = s_aa[A1-1:0];

        for (int p = 0; p < P2; p++) bus2.rd_addr[p*A2 +: A2] = s_ra[p][A2-1:0];
        for (int w = 0; w < W2; w++) begin
            bus2.wr_en[w]             = s_we[w];
            bus2.wr_addr[w*A2 +: A2]  = s_wa[w][A2-1:0];
            bus2.wr_data[w*X2 +: X2]  = s_wd[w][X2-1:0];
        end
        bus2.alloc_en   = s_ae;
        bus2.alloc_addr = s_aa[A2-1:0];

        for (int p = 0; p < P3; p++) bus3.rd_addr[p*A3 +: A3] = s_ra[p][A3-1:0];
        for (int w = 0; w < W3; w++) begin
            bus3.wr_en[w]             = s_we[w];
            bus3.wr_addr[w*A3 +: A3]  = s_wa[w][A3-1:0];
            bus3.wr_data[w*X3 +: X3]  = s_wd[w][X3-1:0];
        end
        bus3.alloc_en   = s_ae;
        bus3.alloc_addr = s_aa[A3-1:0];
    endtask

    // -------------------------------------------------------------------------
    // Compare process: every output of every instance, every cycle
    // -------------------------------------------------------------------------
    task automatic compare_all();
        logic [31:0] g_rd  [NCFG][MAXP];
        logic        g_rb  [NCFG][MAXP];
        logic [31:0] g_vec [NCFG];
        for (int c = 0; c < NCFG; c++) begin
            for (int p = 0; p < MAXP; p++) begin
                g_rd[c][p] = 32'h0;
                g_rb[c][p] = 1'b0;
            end
        end
        for (int p = 0; p < P0; p++) begin
            g_rd[0][p] = 32'(bus0.rd_data[p*X0 +: X0]);
            g_rb[0][p] = bus0.rd_busy[p];
        end
        for (int p = 0; p < P1; p++) begin
            g_rd[1][p] = 32'(bus1.rd_data[p*X1 +: X1]);
            g_rb[1][p] = bus1.rd_busy[p];
        end
        for (int p = 0; p < P2; p++) begin
            g_rd[2][p] = 32'(bus2.rd_data[p*X2 +: X2]);
            g_rb[2][p] = bus2.rd_busy[p];
        end
        for (int p = 0; p < P3; p++) begin
            g_rd[3][p] = 32'(bus3.rd_data[p*X3 +: X3]);
            g_rb[3][p] = bus3.rd_busy[p];
        end
        g_vec[0] = 32'(bus0.busy_vec);
        g_vec[1] = 32'(bus1.busy_vec);
        g_vec[2] = 32'(bus2.busy_vec);
        g_vec[3] = 32'(bus3.busy_vec);

        for (int c = 0; c < NCFG; c++) begin
            for (int p = 0; p < C_P[c]; p++) begin
                check("rd_data", c, p, g_rd[c][p], exp_rd(c, p));
                check("rd_busy", c, p, 32'(g_rb[c][p]), 32'(exp_rb(c, p)));
            end
            check("busy_vec", c, 0, g_vec[c], m_busy[c]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) compare_all();
    end

    // -------------------------------------------------------------------------
    // Sequencing helpers
    // -------------------------------------------------------------------------
    task automatic idle();
        s_rst = 1'b0;
        s_ae  = 1'b0;
        s_aa  = 5'd0;
        for (int p = 0; p < MAXP; p++) s_ra[p] = 5'd0;
        for (int w = 0; w < MAXW; w++) begin
            s_we[w] = 1'b0;
            s_wa[w] = 5'd0;
            s_wd[w] = 32'h0;
        end
    endtask

    // Inputs seen at this edge update the model, then new inputs may be set.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic randomize_inputs();
        idle();
        s_rst = ($urandom_range(0, 255) == 0);
        for (int p = 0; p < MAXP; p++)
            s_ra[p] = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
        for (int w = 0; w < MAXW; w++) begin
            s_we[w] = ($urandom_range(0, 1) == 1);
            s_wa[w] = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            s_wd[w] = $urandom;
        end
        s_ae = ($urandom_range(0, 9) < 4);
        s_aa = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        idle();
        s_rst = 1'b1;
        pack_inputs();
        tick();
        tick();

        // Reset state
        idle();
        pack_inputs();
        chk_en = 1'b1;
        @(negedge clk);
        check("lit_rd_data", 0, 0, bus0.rd_data[31:0], 32'h0);
        check("lit_busy_vec", 0, 0, bus0.busy_vec, 32'h0);
        check("lit_rd_busy", 1, 0, 32'(bus1.rd_busy[0]), 32'h0);
        tick();

        // Reset mid-operation overrides a write and an allocate
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = 32'hDEAD_BEEF; s_ae = 1'b1; s_aa = 5'd7;
        pack_inputs();
        tick();
        idle(); s_ra[0] = 5'd5; s_ra[1] = 5'd7;
        pack_inputs();
        @(negedge clk);
        check("lit_rd_data", 0, 0, bus0.rd_data[31:0], 32'hDEAD_BEEF);
        check("lit_rd_busy", 0, 1, 32'(bus0.rd_busy[1]), 32'h1);
        tick();
        idle(); s_rst = 1'b1; s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = 32'h0000_1234;
        s_ae = 1'b1; s_aa = 5'd11;
        pack_inputs();
        tick();
        idle(); s_ra[0] = 5'd5; s_ra[1] = 5'd7;
        pack_inputs();
        @(negedge clk);
        check("lit_rd_data", 0, 0, bus0.rd_data[31:0], 32'h0);
        check("lit_rd_data", 0, 1, bus0.rd_data[63:32], 32'h0);
        check("lit_busy_vec", 0, 0, bus0.busy_vec, 32'h0);
        check("lit_busy_vec", 1, 0, bus1.busy_vec, 32'h0);
        tick();

        // Zero register: write + allocate of x0
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd0; s_wd[0] = 32'hFFFF_FFFF; s_ae = 1'b1; s_aa = 5'd0;
        pack_inputs();
        @(negedge clk);
        check("lit_rd_data_x0", 0, 0, bus0.rd_data[31:0], 32'h0);
        tick();
        idle();
        pack_inputs();
        @(negedge clk);
        check("lit_rd_data_x0", 0, 0, bus0.rd_data[31:0], 32'h0);
        check("lit_busy_vec0", 0, 0, 32'(bus0.busy_vec[0]), 32'h0);
        check("lit_rd_data_x0", 1, 0, bus1.rd_data[31:0], 32'hFFFF_FFFF);
        check("lit_busy_vec0", 1, 0, 32'(bus1.busy_vec[0]), 32'h1);
        tick();

        // Bypass vs. no bypass
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 32'h11;
        pack_inputs();
        tick();
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 32'h22; s_ra[0] = 5'd3;
        pack_inputs();
        @(negedge clk);
        check("lit_bypass", 0, 0, bus0.rd_data[31:0], 32'h22);
        check("lit_nobypass", 1, 0, bus1.rd_data[31:0], 32'h11);
        tick();
        idle(); s_ra[0] = 5'd3;
        pack_inputs();
        @(negedge clk);
        check("lit_nobypass_next", 1, 0, bus1.rd_data[31:0], 32'h22);
        tick();

        // Scoreboard allocate then write-back
        idle(); s_ae = 1'b1; s_aa = 5'd9;
        pack_inputs();
        tick();
        idle(); s_ra[0] = 5'd9;
        pack_inputs();
        @(negedge clk);
        check("lit_busy_vec9", 0, 0, 32'(bus0.busy_vec[9]), 32'h1);
        check("lit_rd_busy", 0, 0, 32'(bus0.rd_busy[0]), 32'h1);
        tick();
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd9; s_wd[0] = 32'hAB; s_ra[0] = 5'd9;
        pack_inputs();
        @(negedge clk);
        check("lit_rd_busy_wb", 0, 0, 32'(bus0.rd_busy[0]), 32'h0);
        check("lit_rd_data_wb", 0, 0, bus0.rd_data[31:0], 32'hAB);
        check("lit_rd_busy_wb", 1, 0, 32'(bus1.rd_busy[0]), 32'h1);
        tick();
        idle(); s_ra[0] = 5'd9;
        pack_inputs();
        @(negedge clk);
        check("lit_busy_vec9", 0, 0, 32'(bus0.busy_vec[9]), 32'h0);
        check("lit_rd_data", 1, 0, bus1.rd_data[31:0], 32'hAB);
        tick();

        // Simultaneous set and clear on a busy register
        idle(); s_ae = 1'b1; s_aa = 5'd4;
        pack_inputs();
        tick();
        idle(); s_ae = 1'b1; s_aa = 5'd4; s_we[0] = 1'b1; s_wa[0] = 5'd4; s_wd[0] = 32'h55;
        pack_inputs();
        tick();
        idle(); s_ra[0] = 5'd4;
        pack_inputs();
        @(negedge clk);
        check("lit_busy_vec4", 0, 0, 32'(bus0.busy_vec[4]), 32'h1);
        check("lit_rd_data", 0, 0, bus0.rd_data[31:0], 32'h55);
        tick();

        // Two ports writing the same register: port 1 wins
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd6; s_wd[0] = 32'hA;
        s_we[1] = 1'b1; s_wa[1] = 5'd6; s_wd[1] = 32'hB; s_ra[0] = 5'd6; s_ra[1] = 5'd6;
        pack_inputs();
        @(negedge clk);
        check("lit_conflict_bypass", 0, 0, bus0.rd_data[31:0], 32'hB);
        check("lit_conflict_bypass", 0, 1, bus0.rd_data[63:32], 32'hB);
        tick();
        idle(); s_ra[0] = 5'd6;
        pack_inputs();
        @(negedge clk);
        check("lit_conflict_stored", 0, 0, bus0.rd_data[31:0], 32'hB);
        check("lit_conflict_stored", 1, 0, bus1.rd_data[31:0], 32'hB);
        tick();

        // Randomised run against the model
        for (int i = 0; i < N_RANDOM; i++) begin
            randomize_inputs();
            pack_inputs();
            tick();
        end

        idle();
        pack_inputs();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
